vote_sgpr: RTL and testbench
============================

Name: vote_sgpr

Overview:
- Parametrised successor to the two-lane compare-then-write shared GPR.
- Accepts write ports from NUM_LANES redundant cores (2 = duplex compare, 3 = TMR majority vote) and commits only agreed or majority writes to a 2-read/1-write register file.
- Adds a retry/fault state machine, sticky per-lane fault flags and a saturating error counter.
- Sits between the redundant cores' writeback stages and the shared register file read ports.

Parameters:
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_LANES, 3, number of redundant write lanes; legal values are 2 or 3 only (elaboration error otherwise).
- MAX_RETRY, 3, unresolved mismatches tolerated in RETRY before entering FAULT; range 1..15.
- ERR_CNT_WIDTH, 8, width of the error event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we_i  in  NUM_LANES  per-lane write enable; lane k is bit k.
- waddr_i  in  NUM_LANES*ADDR_WIDTH  per-lane write address; lane k occupies slice k.
- wdata_i  in  NUM_LANES*DATA_WIDTH  per-lane write data; lane k occupies slice k.
- raddr_a_i  in  ADDR_WIDTH  read port A address.
- rdata_a_o  out  DATA_WIDTH  read port A data, combinational.
- raddr_b_i  in  ADDR_WIDTH  read port B address.
- rdata_b_o  out  DATA_WIDTH  read port B data, combinational.
- clear_i  in  1  synchronous clear of FAULT state, lane flags and error counter.
- stall_o  out  1  cores hold writeback; high in RETRY and FAULT.
- retry_o  out  1  one-cycle pulse requesting the cores to re-issue the write.
- fault_o  out  1  sticky unrecoverable fault.
- faulty_lane_o  out  NUM_LANES  sticky per-lane outvoted flags.
- err_cnt_o  out  ERR_CNT_WIDTH  saturating count of mismatch events.
- rd_perr_o  out  1  read parity error on port A or B.

Behaviour:
- Lane tuple T_k = {we_i[k], waddr_i slice k, wdata_i slice k}. Lanes agree when tuples are bitwise equal.
- Read: register 0 always reads 0. Reads are combinational with no write-to-read bypass; a write becomes visible the cycle after its commit edge.
- Reset: all registers 0, state RUN, stall_o=0, retry_o=0, fault_o=0, faulty_lane_o=0, err_cnt_o=0, retry counter 0, rd_perr_o=0.
- Outcome classification, evaluated every cycle:
  - All lanes agree: commit if we=1 and addr≠0.
  - NUM_LANES=3, exactly two agree: commit the majority tuple (same rules as above), set faulty_lane_o for the minority lane, err_cnt++. No stall.
  - Otherwise: unresolved. No commit.
- States:
  - RUN: an unresolved outcome increments err_cnt, sets the retry counter to 1, pulses retry_o, and moves to RETRY.
  - RETRY: stall_o=1. If lanes agree or a majority exists, commit, clear the retry counter and return to RUN. If unresolved and retry counter < MAX_RETRY, increment it, err_cnt++ and pulse retry_o again. If unresolved and retry counter == MAX_RETRY, move to FAULT with err_cnt++.
  - FAULT: stall_o=1, fault_o=1, no commits. Reads remain functional.
- clear_i, any state: next state RUN; faulty_lane_o, err_cnt_o and retry counter cleared; no commit that cycle. clear_i has priority over all other events.
- err_cnt_o saturates at all-ones; no wrap.
- All-lanes we=0 with differing addr/data counts as a mismatch. Tuples are compared in full, not only when enabled.
- Reset asserted mid-RETRY returns to the reset values immediately (asynchronous); registers are cleared.

Optional Feature:
- Macro VOTE_SGPR_PARITY_EN.
- Defined: each register stores an extra even-parity bit computed at commit. rd_perr_o = parity mismatch on port A or port B (register 0 excluded), combinational.
- Not defined: no parity storage; rd_perr_o tied to 0.

Test Plan:
- NUM_LANES=3, all lanes write addr 5 data 0xDEADBEEF -> next cycle rdata_a_o=0xDEADBEEF with raddr_a_i=5; err_cnt_o=0; stall_o=0.
- NUM_LANES=3, lane 2 data 0x1 and lanes 0/1 data 0xCAFE at addr 7 -> reg7=0xCAFE, faulty_lane_o=3'b100, err_cnt_o=1, no stall.
- NUM_LANES=2, one mismatch at addr 3, then matching 0x55 on the next cycle -> retry_o pulses once, stall_o high for 1 cycle, reg3=0x55, state RUN.
- NUM_LANES=2, MAX_RETRY=3, persistent mismatch -> retry_o pulses 3 times, then fault_o=1 and err_cnt_o=4; clear_i -> fault_o=0, err_cnt_o=0, stall_o=0.
- Write to addr 0 with data 0xFFFFFFFF by all lanes -> read addr 0 returns 0; error counter saturation: force 260 minority events with ERR_CNT_WIDTH=8 -> err_cnt_o=255.
- VOTE_SGPR_PARITY_EN defined, flip a stored bit of reg 9 via hierarchical force -> rd_perr_o=1 when raddr_b_i=9, 0 otherwise.

Source files
------------

// File: rtl/vote_sgpr.sv
// Voting shared GPR: 2/3-lane compare or majority commit with retry/fault FSM.
// Optional VOTE_SGPR_PARITY_EN adds per-register even parity and read check.
module vote_sgpr #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_LANES     = 3,
  parameter int MAX_RETRY     = 3,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            we_i,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0]           raddr_a_i,
  output logic [DATA_WIDTH-1:0]           rdata_a_o,
  input  logic [ADDR_WIDTH-1:0]           raddr_b_i,
  output logic [DATA_WIDTH-1:0]           rdata_b_o,
  input  logic                            clear_i,
  output logic                            stall_o,
  output logic                            retry_o,
  output logic                            fault_o,
  output logic [NUM_LANES-1:0]            faulty_lane_o,
  output logic [ERR_CNT_WIDTH-1:0]        err_cnt_o,
  output logic                            rd_perr_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int TW    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [3:0] MAXR = 4'(MAX_RETRY);

  if (NUM_LANES != 2 && NUM_LANES != 3) begin : g_bad_lanes
    $error("vote_sgpr: NUM_LANES must be 2 or 3");
  end
  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_retry
    $error("vote_sgpr: MAX_RETRY must be 1..15");
  end

  typedef enum logic [1:0] {S_RUN, S_RETRY, S_FAULT} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               rcnt_q, rcnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d, err_inc;
  logic [NUM_LANES-1:0]     flags_q, flags_d;
  logic                     retry_q, retry_d;
  logic                     commit;

  logic [TW-1:0]            tup [NUM_LANES];
  logic                     all_eq, maj_ok, resolved;
  logic [NUM_LANES-1:0]     minority;
  logic [TW-1:0]            win;
  logic                     win_we;
  logic [ADDR_WIDTH-1:0]    win_addr;
  logic [DATA_WIDTH-1:0]    win_data;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_tup
    assign tup[k] = {we_i[k],
                     waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
                     wdata_i[k*DATA_WIDTH +: DATA_WIDTH]};
  end

  if (NUM_LANES == 3) begin : g_tmr
    logic e01, e02, e12;
    assign e01 = tup[0] == tup[1];
    assign e02 = tup[0] == tup[2];
    assign e12 = tup[1] == tup[2];
    assign all_eq   = e01 & e12;
    assign maj_ok   = ~all_eq & (e01 | e02 | e12);
    // With lanes not all equal, at most one pair matches; its odd lane is out.
    assign minority = all_eq ? '0 : {e01, e02, e12};
    assign win      = e12 ? tup[1] : tup[0];
  end else begin : g_dmr
    assign all_eq   = tup[0] == tup[1];
    assign maj_ok   = 1'b0;
    assign minority = '0;
    assign win      = tup[0];
  end

  assign resolved = all_eq | maj_ok;
  assign win_we   = win[TW-1];
  assign win_addr = win[DATA_WIDTH +: ADDR_WIDTH];
  assign win_data = win[DATA_WIDTH-1:0];
  assign err_inc  = (err_q == '1) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    err_d   = err_q;
    flags_d = flags_q;
    retry_d = 1'b0;
    commit  = 1'b0;
    if (clear_i) begin
      state_d = S_RUN;
      rcnt_d  = '0;
      err_d   = '0;
      flags_d = '0;
    end else if (state_q != S_FAULT) begin
      if (resolved) begin
        commit  = win_we && (win_addr != '0);
        state_d = S_RUN;
        rcnt_d  = '0;
        if (maj_ok) begin
          flags_d = flags_q | minority;
          err_d   = err_inc;
        end
      end else begin
        err_d = err_inc;
        if (state_q == S_RUN) begin
          state_d = S_RETRY;
          rcnt_d  = 4'd1;
          retry_d = 1'b1;
        end else if (rcnt_q < MAXR) begin
          rcnt_d  = rcnt_q + 4'd1;
          retry_d = 1'b1;
        end else begin
          state_d = S_FAULT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      rcnt_q  <= '0;
      err_q   <= '0;
      flags_q <= '0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
      flags_q <= flags_d;
      retry_q <= retry_d;
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[win_addr] <= win_data;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

`ifdef VOTE_SGPR_PARITY_EN
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else if (commit) begin
      par_q[win_addr] <= ^win_data;
    end
  end

  assign rd_perr_o =
    ((raddr_a_i != '0) && ((^mem_q[raddr_a_i]) != par_q[raddr_a_i])) ||
    ((raddr_b_i != '0) && ((^mem_q[raddr_b_i]) != par_q[raddr_b_i]));
`else
  assign rd_perr_o = 1'b0;
`endif

  assign stall_o       = state_q != S_RUN;
  assign fault_o       = state_q == S_FAULT;
  assign retry_o       = retry_q;
  assign faulty_lane_o = flags_q;
  assign err_cnt_o     = err_q;

endmodule

// File: tb/tb_vote_sgpr.sv
// Bench for vote_sgpr: a 3-lane and a 2-lane instance share lane stimulus
// and are checked every cycle against a behavioural model plus literals.
module tb_vote_sgpr;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = 8;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [2:0] we = '0;
  logic [3*AW-1:0] wa = '0;
  logic [3*DW-1:0] wd = '0;
  logic [AW-1:0] ra = '0, rb = '0;
  bit inj = 0;

  logic [DW-1:0] rda3, rdb3, rda2, rdb2;
  logic st3, rt3, ft3, pe3, st2, rt2, ft2, pe2;
  logic [2:0] fl3;
  logic [1:0] fl2;
  logic [EW-1:0] ec3, ec2;

  always #5 clk = ~clk;

  vote_sgpr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(3),
              .MAX_RETRY(MR), .ERR_CNT_WIDTH(EW)) u3 (
    .clk(clk), .rst_n(rst_n), .we_i(we), .waddr_i(wa), .wdata_i(wd),
    .raddr_a_i(ra), .rdata_a_o(rda3), .raddr_b_i(rb), .rdata_b_o(rdb3),
    .clear_i(clear), .stall_o(st3), .retry_o(rt3), .fault_o(ft3),
    .faulty_lane_o(fl3), .err_cnt_o(ec3), .rd_perr_o(pe3));

  vote_sgpr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_LANES(2),
              .MAX_RETRY(MR), .ERR_CNT_WIDTH(EW)) u2 (
    .clk(clk), .rst_n(rst_n), .we_i(we[1:0]), .waddr_i(wa[2*AW-1:0]),
    .wdata_i(wd[2*DW-1:0]),
    .raddr_a_i(ra), .rdata_a_o(rda2), .raddr_b_i(rb), .rdata_b_o(rdb2),
    .clear_i(clear), .stall_o(st2), .retry_o(rt2), .fault_o(ft2),
    .faulty_lane_o(fl2), .err_cnt_o(ec2), .rd_perr_o(pe2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Model: index 0 = 3-lane instance, 1 = 2-lane instance.
  // mode 0 = running, 1 = retrying, 2 = faulted.
  logic [DW-1:0] m_reg [2][32];
  int m_mode [2];
  int m_rcnt [2];
  int m_err [2];
  logic [2:0] m_flag [2];
  bit m_retry [2];

  function automatic bit same(input int a, input int b);
    return we[a] == we[b] && wa[a*AW +: AW] == wa[b*AW +: AW] &&
           wd[a*DW +: DW] == wd[b*DW +: DW];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) m_reg[i][r] = '0;
      m_mode[i] = 0; m_rcnt[i] = 0; m_err[i] = 0;
      m_flag[i] = '0; m_retry[i] = 0;
    end
  endtask

  task automatic bump(input int i);
    if (m_err[i] < 255) m_err[i]++;
  endtask

  task automatic mstep(input int i, input int n);
    bit res;
    int src, mino;
    res = 0; src = 0; mino = -1;
    if (n == 2) res = same(0, 1);
    else if (same(0, 1) && same(1, 2)) res = 1;
    else
      for (int k = 0; k < 3; k++) begin
        if (same((k + 1) % 3, (k + 2) % 3)) begin
          res = 1; src = (k + 1) % 3; mino = k;
        end
      end
    m_retry[i] = 0;
    if (clear) begin
      m_mode[i] = 0; m_rcnt[i] = 0; m_err[i] = 0; m_flag[i] = '0;
    end else if (m_mode[i] != 2) begin
      if (res) begin
        if (we[src] && wa[src*AW +: AW] != 0)
          m_reg[i][wa[src*AW +: AW]] = wd[src*DW +: DW];
        m_mode[i] = 0; m_rcnt[i] = 0;
        if (mino >= 0) begin m_flag[i][mino] = 1'b1; bump(i); end
      end else begin
        bump(i);
        if (m_mode[i] == 0) begin
          m_mode[i] = 1; m_rcnt[i] = 1; m_retry[i] = 1;
        end else if (m_rcnt[i] < MR) begin
          m_rcnt[i]++; m_retry[i] = 1;
        end else m_mode[i] = 2;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mreset();
    else begin mstep(0, 3); mstep(1, 2); end

  function automatic logic [DW-1:0] erd(input int i, input logic [AW-1:0] a);
    return (a == 0) ? '0 : m_reg[i][a];
  endfunction

  always @(negedge clk) if (rst_n) begin
    chk("m3_rda", rda3, erd(0, ra));
    chk("m3_rdb", rdb3, erd(0, rb));
    chk("m3_stall", st3, m_mode[0] != 0);
    chk("m3_retry", rt3, m_retry[0]);
    chk("m3_fault", ft3, m_mode[0] == 2);
    chk("m3_flags", fl3, m_flag[0]);
    chk("m3_err", ec3, m_err[0]);
    chk("m3_perr", pe3, inj && (ra == 9 || rb == 9));
    chk("m2_rda", rda2, erd(1, ra));
    chk("m2_rdb", rdb2, erd(1, rb));
    chk("m2_stall", st2, m_mode[1] != 0);
    chk("m2_retry", rt2, m_retry[1]);
    chk("m2_fault", ft2, m_mode[1] == 2);
    chk("m2_flags", fl2, m_flag[1][1:0]);
    chk("m2_err", ec2, m_err[1]);
    chk("m2_perr", pe2, 1'b0);
  end

  task automatic lanes(input logic [2:0] w,
                       input logic [AW-1:0] a0, a1, a2,
                       input logic [DW-1:0] d0, d1, d2);
    we = w; wa = {a2, a1, a0}; wd = {d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int pulses;

  initial begin
    lanes(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", st3, 1'b0);
    chk("rst_retry", rt3, 1'b0);
    chk("rst_fault", ft3, 1'b0);
    chk("rst_flags", fl3, 3'b000);
    chk("rst_err", ec3, 8'd0);
    chk("rst_perr", pe3, 1'b0);
    rst_n = 1'b1;

    lanes(3'b111, 5, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    ra = 5;
    tick();
    chk("agree_rd3", rda3, 32'hDEADBEEF);
    chk("agree_rd2", rda2, 32'hDEADBEEF);
    chk("agree_err", ec3, 8'd0);
    chk("agree_stall", st3, 1'b0);

    lanes(3'b111, 7, 7, 7, 32'hCAFE, 32'hCAFE, 32'h1);
    ra = 7;
    tick();
    chk("maj_rd", rda3, 32'hCAFE);
    chk("maj_flags", fl3, 3'b100);
    chk("maj_err", ec3, 8'd1);
    chk("maj_stall", st3, 1'b0);

    lanes(3'b111, 3, 3, 3, 32'h11, 32'h22, 32'h33);
    ra = 3;
    tick();
    chk("rt1_retry", rt2, 1'b1);
    chk("rt1_stall", st2, 1'b1);
    lanes(3'b111, 3, 3, 3, 32'h55, 32'h55, 32'h55);
    tick();
    chk("rt1_stall_end", st2, 1'b0);
    chk("rt1_retry_end", rt2, 1'b0);
    chk("rt1_rd", rda2, 32'h55);
    chk("rt1_err2", ec2, 8'd1);
    chk("rt1_err3", ec3, 8'd2);

    lanes(3'b000, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_err", ec3, 8'd0);
    chk("clr_flags", fl3, 3'b000);

    lanes(3'b111, 3, 3, 3, 32'h1, 32'h2, 32'h4);
    pulses = 0;
    repeat (6) begin
      tick();
      pulses += int'(rt2);
    end
    chk("flt_pulses", pulses, 3);
    chk("flt_fault", ft2, 1'b1);
    chk("flt_err", ec2, 8'd4);
    chk("flt_stall", st2, 1'b1);
    chk("flt_rd_ok", rda2, 32'h55);
    lanes(3'b000, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("flt_clr_fault", ft2, 1'b0);
    chk("flt_clr_err", ec2, 8'd0);
    chk("flt_clr_stall", st2, 1'b0);

    lanes(3'b111, 0, 0, 0, '1, '1, '1);
    ra = 0;
    tick();
    chk("r0_zero", rda3, 32'h0);

    lanes(3'b000, 1, 2, 3, 0, 0, 0);
    tick();
    chk("we0_mis_stall", st3, 1'b1);
    chk("we0_mis_err", ec3, 8'd1);
    lanes(3'b000, 0, 0, 0, 0, 0, 0);
    tick();

    for (int k = 0; k < 16; k++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'((k * 7 + 1) % 32);
      d = 32'h1111 * (k + 1);
      if (k % 4 == 0) begin
        if (k % 3 == 0) lanes(3'b111, a, a, a, d ^ 32'h80, d, d);
        else if (k % 3 == 1) lanes(3'b111, a, a, a, d, d ^ 32'h80, d);
        else lanes(3'b111, a, a, a, d, d, d ^ 32'h80);
      end else lanes(3'b111, a, a, a, d, d, d);
      rb = AW'(k);
      ra = a;
      tick();
    end

    lanes(3'b000, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    lanes(3'b100, 1, 1, 1, 0, 0, 0);
    repeat (260) tick();
    chk("sat_err", ec3, 8'd255);
    chk("sat_flags", fl3, 3'b100);
    chk("sat_stall", st3, 1'b0);

    lanes(3'b111, 3, 3, 3, 32'h7, 32'h8, 32'h9);
    ra = 3;
    tick();
    chk("ar_pre_stall", st2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_stall", st2, 1'b0);
    chk("ar_retry", rt2, 1'b0);
    chk("ar_err", ec2, 8'd0);
    chk("ar_reg", rda2, 32'h0);
    lanes(3'b000, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

`ifdef VOTE_SGPR_PARITY_EN
    begin
      logic p;
      lanes(3'b111, 9, 9, 9, 32'h0F0F, 32'h0F0F, 32'h0F0F);
      tick();
      lanes(3'b000, 0, 0, 0, 0, 0, 0);
      ra = 0;
      rb = 9;
      #1;
      chk("par_clean", pe3, 1'b0);
      p = u3.par_q[9];
      force u3.par_q[9] = ~p;
      inj = 1;
      #1;
      chk("par_hit", pe3, 1'b1);
      rb = 8;
      #1;
      chk("par_other", pe3, 1'b0);
      tick();
      release u3.par_q[9];
      inj = 0;
    end
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
